// File: rtl/tensor_commit_collector_if.sv
// Commit-beat input stream and assembled-tile output stream of the tensor commit collector.
// The master drives beats and accepts tiles; the slave is the collector.
interface tensor_commit_collector_if #(
  parameter int NUM_THREADS = 8,
  parameter int XLEN        = 32,
  parameter int UUID_W      = 44,
  parameter int NW_W        = 2,
  parameter int NR_W        = 6
);
  localparam int NUM_OCTETS = NUM_THREADS / 8;

  logic                          in_valid;
  logic                          in_ready;
  logic [UUID_W-1:0]             in_uuid;
  logic [NW_W-1:0]               in_wid;
  logic [NR_W-1:0]               in_rd;
  logic [NUM_THREADS*XLEN-1:0]   in_data;

  logic                          out_valid;
  logic                          out_ready;
  logic [UUID_W-1:0]             out_uuid;
  logic [NW_W-1:0]               out_wid;
  logic [NR_W-1:0]               out_rd;
  logic [NUM_OCTETS*16*32-1:0]   out_tile;

  modport master (
    output in_valid, in_uuid, in_wid, in_rd, in_data, out_ready,
    input  in_ready, out_valid, out_uuid, out_wid, out_rd, out_tile
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_rd, in_data, out_ready,
    output in_ready, out_valid, out_uuid, out_wid, out_rd, out_tile
  );
endinterface

// File: rtl/tensor_commit_collector.sv
// Pairs two HMMA commit beats into per-octet 4x4 fp32 D tiles; tile valid the cycle after beat1.
// Holds the tile and stalls beats while the consumer backpressures; a beat may enter as the tile leaves.
module tensor_commit_collector #(
  parameter int NUM_THREADS = 8,
  parameter int XLEN        = 32,
  parameter int UUID_W      = 44,
  parameter int NW_W        = 2,
  parameter int NR_W        = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  tensor_commit_collector_if.slave     bus,
  output logic                         err_mismatch,
  output logic [31:0]                  tile_count
);
  localparam int NUM_OCTETS = NUM_THREADS / 8;
  localparam int L          = 4 * NUM_OCTETS;
  localparam int TAG_W      = UUID_W + NW_W + NR_W;
  localparam int TILE_W     = NUM_OCTETS * 16 * 32;

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_d;
  logic              in_rdy, in_fire, out_fire, cap0, cap1;
  logic [TAG_W-1:0]  in_tag, tag_q;
  logic [TILE_W-1:0] tile_q;

  assign in_tag = {bus.in_uuid, bus.in_wid, bus.in_rd};

  always_comb begin
    state_d  = state;
    in_rdy   = !flush && (state != FULL || bus.out_ready);
    in_fire  = bus.in_valid && in_rdy;
    out_fire = (state == FULL) && bus.out_ready;
    cap0     = in_fire && (state != HALF);
    cap1     = in_fire && (state == HALF);
    case (state)
      EMPTY: if (in_fire) state_d = HALF;
      HALF: begin
        if (flush)        state_d = EMPTY;
        else if (in_fire) state_d = FULL;
      end
      FULL: if (out_fire) state_d = in_fire ? HALF : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q        <= '0;
      err_mismatch <= 1'b0;
      tile_count   <= 32'd0;
    end else begin
      if (cap0) tag_q <= in_tag;
      if (cap1 && (in_tag != tag_q)) err_mismatch <= 1'b1;
      if (out_fire) tile_count <= tile_count + 32'd1;
    end
  end

  // Lane 4o+j feeds rows 0/1 and lane 4o+L+j rows 2/3; odd j selects the odd row,
  // j>=2 selects column 2; beat1 lands one column to the right of beat0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_q <= '0;
    end else begin
      for (int o = 0; o < NUM_OCTETS; o++) begin
        for (int h = 0; h < 2; h++) begin
          for (int j = 0; j < 4; j++) begin
            if (cap0)
              tile_q[((o*4 + 2*h + j%2)*4 + (j/2)*2)*32 +: 32]
                <= bus.in_data[(4*o + h*L + j)*XLEN +: 32];
            if (cap1)
              tile_q[((o*4 + 2*h + j%2)*4 + (j/2)*2 + 1)*32 +: 32]
                <= bus.in_data[(4*o + h*L + j)*XLEN +: 32];
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == FULL);
  assign {bus.out_uuid, bus.out_wid, bus.out_rd} = tag_q;
  assign bus.out_tile  = tile_q;
endmodule

// File: tb/tb_tensor_commit_collector.sv
// Directed bench for tensor_commit_collector with 8 lanes (one octet): table of tiles plus
// back-to-back, backpressure, tag mismatch, flush and mid-tile reset sequences.
module tb_tensor_commit_collector;
  localparam int TW = 512;
  localparam int DW = 256;

  logic        clk, reset, flush, err_mismatch;
  logic [31:0] tile_count;
  int          n_chk = 0, n_err = 0;
  int          exp_cnt = 0;

  tensor_commit_collector_if #(.NUM_THREADS(8), .XLEN(32), .UUID_W(44), .NW_W(2), .NR_W(6)) bus ();

  tensor_commit_collector #(.NUM_THREADS(8), .XLEN(32), .UUID_W(44), .NW_W(2), .NR_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .err_mismatch(err_mismatch), .tile_count(tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic [43:0]   uuid;
    logic [1:0]    wid;
    logic [5:0]    rd;
    logic [TW-1:0] exp_tile;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [DW-1:0] pat(input logic [31:0] base);
    logic [DW-1:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = base + 32'(i);
    return p;
  endfunction

  // Inverse view: for each D[r][c], which beat and which lane it came from.
  function automatic logic [TW-1:0] ref_tile(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    logic [TW-1:0] t;
    logic [DW-1:0] src;
    int lane;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        lane = ((r >= 2) ? 4 : 0) + (r % 2) + ((c >= 2) ? 2 : 0);
        src  = (c % 2 == 0) ? b0 : b1;
        t[(r*4 + c)*32 +: 32] = src[lane*32 +: 32];
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] word(input logic [TW-1:0] t, input int r, input int c);
    return t[(r*4 + c)*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [43:0] u, input logic [1:0] w,
                      input logic [5:0] r);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_uuid  = u;
    bus.in_wid   = w;
    bus.in_rd    = r;
    flush        = 1'b0;
    #1;
    chk("in_ready_on_beat", TW'(bus.in_ready), TW'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{pat(32'h10), pat(32'h20), 44'h123, 2'd1, 6'd3, '0};
    vecs[1] = '{pat(32'hA5A5_0000), pat(32'h5A5A_0100), 44'hFFF_FFFF_FFFF, 2'd3, 6'd63, '0};
    vecs[2] = '{pat(32'hDEAD_0000), pat(32'h0), 44'h0, 2'd2, 6'h2A, '0};
    for (int v = 0; v < 3; v++) vecs[v].exp_tile = ref_tile(vecs[v].b0, vecs[v].b1);

    // T1 reset
    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_uuid = '0; bus.in_wid = '0; bus.in_rd = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", TW'(bus.out_valid), TW'(0));
    chk("rst_in_ready", TW'(bus.in_ready), TW'(1));
    chk("rst_tile_count", TW'(tile_count), TW'(0));
    chk("rst_err", TW'(err_mismatch), TW'(0));
    chk("rst_tile", bus.out_tile, '0);

    // T2 and table of tiles
    for (int v = 0; v < 3; v++) begin
      beat(vecs[v].b0, vecs[v].uuid, vecs[v].wid, vecs[v].rd);
      chk("tbl_valid_half", TW'(bus.out_valid), TW'(0));
      beat(vecs[v].b1, vecs[v].uuid, vecs[v].wid, vecs[v].rd);
      idle();
      chk("tbl_out_valid", TW'(bus.out_valid), TW'(1));
      chk("tbl_tile", bus.out_tile, vecs[v].exp_tile);
      chk("tbl_uuid", TW'(bus.out_uuid), TW'(vecs[v].uuid));
      chk("tbl_wid", TW'(bus.out_wid), TW'(vecs[v].wid));
      chk("tbl_rd", TW'(bus.out_rd), TW'(vecs[v].rd));
      if (v == 0) begin
        chk("t2_d00", TW'(word(bus.out_tile, 0, 0)), TW'(32'h10));
        chk("t2_d10", TW'(word(bus.out_tile, 1, 0)), TW'(32'h11));
        chk("t2_d02", TW'(word(bus.out_tile, 0, 2)), TW'(32'h12));
        chk("t2_d20", TW'(word(bus.out_tile, 2, 0)), TW'(32'h14));
        chk("t2_d33", TW'(word(bus.out_tile, 3, 3)), TW'(32'h27));
        chk("t2_d01", TW'(word(bus.out_tile, 0, 1)), TW'(32'h20));
      end
      idle();
      exp_cnt++;
      chk("tbl_count", TW'(tile_count), TW'(exp_cnt));
      chk("tbl_valid_drop", TW'(bus.out_valid), TW'(0));
    end

    // T3 back-to-back: 8 beats, tiles leave while the next beat0 arrives
    for (int k = 0; k < 8; k++) begin
      beat(pat(32'h1000 * (k + 1)), 44'(k / 2), 2'd0, 6'd0);
      chk("b2b_out_valid", TW'(bus.out_valid), TW'((k >= 2 && k % 2 == 0) ? 1 : 0));
      if (k >= 2 && k % 2 == 0) begin
        chk("b2b_uuid", TW'(bus.out_uuid), TW'(k / 2 - 1));
        chk("b2b_tile", bus.out_tile, ref_tile(pat(32'h1000 * (k - 1)), pat(32'h1000 * k)));
      end
    end
    idle();
    chk("b2b_last_valid", TW'(bus.out_valid), TW'(1));
    chk("b2b_last_uuid", TW'(bus.out_uuid), TW'(3));
    idle();
    exp_cnt += 4;
    chk("b2b_count", TW'(tile_count), TW'(exp_cnt));

    // T4 backpressure
    bus.out_ready = 1'b0;
    beat(pat(32'h40), 44'h77, 2'd1, 6'd7);
    beat(pat(32'h50), 44'h77, 2'd1, 6'd7);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = pat(32'h60); bus.in_uuid = 44'h88;
      bus.in_wid = 2'd2; bus.in_rd = 6'd9;
      #1;
      chk("bp_in_ready", TW'(bus.in_ready), TW'(0));
      chk("bp_out_valid", TW'(bus.out_valid), TW'(1));
      chk("bp_tile_stable", bus.out_tile, ref_tile(pat(32'h40), pat(32'h50)));
      chk("bp_uuid_stable", TW'(bus.out_uuid), TW'(44'h77));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", TW'(bus.in_ready), TW'(1));
    idle();
    exp_cnt++;
    chk("bp_half_valid", TW'(bus.out_valid), TW'(0));
    chk("bp_count", TW'(tile_count), TW'(exp_cnt));
    beat(pat(32'h70), 44'h88, 2'd2, 6'd9);
    idle();
    chk("bp_next_valid", TW'(bus.out_valid), TW'(1));
    chk("bp_next_tile", bus.out_tile, ref_tile(pat(32'h60), pat(32'h70)));
    chk("bp_next_uuid", TW'(bus.out_uuid), TW'(44'h88));
    idle();
    exp_cnt++;
    chk("bp_next_count", TW'(tile_count), TW'(exp_cnt));
    chk("pre_mm_err", TW'(err_mismatch), TW'(0));

    // T5 tag mismatch
    beat(pat(32'h80), 44'h5, 2'd0, 6'd5);
    beat(pat(32'h90), 44'h5, 2'd0, 6'd6);
    idle();
    chk("mm_out_valid", TW'(bus.out_valid), TW'(1));
    chk("mm_rd", TW'(bus.out_rd), TW'(5));
    chk("mm_err", TW'(err_mismatch), TW'(1));
    chk("mm_tile", bus.out_tile, ref_tile(pat(32'h80), pat(32'h90)));
    idle();
    exp_cnt++;
    repeat (3) idle();
    chk("mm_err_sticky", TW'(err_mismatch), TW'(1));
    chk("mm_count", TW'(tile_count), TW'(exp_cnt));

    // T6 flush discards a half tile
    beat(pat(32'hA0), 44'h9, 2'd1, 6'd1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = pat(32'hB0); flush = 1'b1;
    #1;
    chk("fl_in_ready", TW'(bus.in_ready), TW'(0));
    idle();
    chk("fl_out_valid", TW'(bus.out_valid), TW'(0));
    beat(pat(32'hC0), 44'hA, 2'd2, 6'd2);
    chk("fl_c_valid", TW'(bus.out_valid), TW'(0));
    beat(pat(32'hD0), 44'hA, 2'd2, 6'd2);
    chk("fl_d_valid", TW'(bus.out_valid), TW'(0));
    idle();
    chk("fl_tile_valid", TW'(bus.out_valid), TW'(1));
    chk("fl_tile", bus.out_tile, ref_tile(pat(32'hC0), pat(32'hD0)));
    chk("fl_uuid", TW'(bus.out_uuid), TW'(44'hA));
    chk("fl_err_kept", TW'(err_mismatch), TW'(1));
    idle();
    exp_cnt++;
    chk("fl_count", TW'(tile_count), TW'(exp_cnt));

    // Asynchronous reset mid-tile
    beat(pat(32'hE0), 44'hB, 2'd3, 6'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_count", TW'(tile_count), TW'(0));
    chk("ar_err", TW'(err_mismatch), TW'(0));
    chk("ar_tile", bus.out_tile, '0);
    chk("ar_uuid", TW'(bus.out_uuid), TW'(0));
    @(negedge clk);
    reset = 1'b1;
    beat(pat(32'hF0), 44'hC, 2'd0, 6'd8);
    beat(pat(32'h100), 44'hC, 2'd0, 6'd8);
    idle();
    chk("ar_tile_valid", TW'(bus.out_valid), TW'(1));
    chk("ar_new_tile", bus.out_tile, ref_tile(pat(32'hF0), pat(32'h100)));
    idle();
    chk("ar_new_count", TW'(tile_count), TW'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
